reu_reg_param: RTL and testbench

Parametrised REU register file for the C64 RAM Expansion Unit CPLD/FPGA. It holds the CPU-visible registers at $DF00–$DF0A and the address/length counters the DMA sequencer advances. It drives the REU address to the SDRAM controller and the C64 address to the bus. REU address width and the status size bit are parameters, so one block serves 128 KiB to 16 MiB expansions. IRQ/status race and wrap behaviour are fully defined.

---
 rtl/reu_reg_param_if.sv | 28 ++
 rtl/reu_reg_param.sv | 269 ++++++++++++++++++++++++++
 tb/tb_reu_reg_param.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reu_reg_param_if.sv
// reu_reg_param_if: C64 CPU register bus into the REU register file.
// Master is the bus decoder side, slave is the register file.
interface reu_reg_param_if;
    logic       RegRD;
    logic       RegWR;
    logic       FF00WR;
    logic [4:0] A;
    logic [7:0] WRD;
    logic [7:0] RDD;

    modport master (
        output RegRD,
        output RegWR,
        output FF00WR,
        output A,
        output WRD,
        input  RDD
    );

    modport slave (
        input  RegRD,
        input  RegWR,
        input  FF00WR,
        input  A,
        input  WRD,
        output RDD
    );
endinterface

// File: rtl/reu_reg_param.sv
// reu_reg_param: REU register file ($DF00-$DF0A) with DMA address and
// length counters; REU address width and status size bit are parameters.
module reu_reg_param #(
    parameter int   REUA_W   = 19,
    parameter logic SIZE_BIT = 1'b1
) (
    input  logic              PHI2,
    input  logic              Reset,
    reu_reg_param_if.slave    bus,
    input  logic              IncCA,
    input  logic              IncREUA,
    input  logic              DecLen,
    input  logic              XferEnd,
    input  logic              SetEndOfBlock,
    input  logic              SetVerifyErr,
    output logic              IRQOut,
    output logic [1:0]        XferTypeOut,
    output logic [REUA_W-1:0] REUAOut,
    output logic [15:0]       CAOut,
    output logic              Length1,
    output logic              Length2,
    output logic              Execute
);

    // Width of the REU address bits held in register 6.
    localparam int HW = REUA_W - 16;

    // Status flags.
    logic ipend_q, ipend_d;
    logic eob_q, eob_d;
    logic fault_q, fault_d;

    // Command register fields.
    logic       exec_en_q, exec_en_d;
    logic       rsv6_q, rsv6_d;
    logic       autold_en_q, autold_en_d;
    logic       ff00_en_q, ff00_en_d;
    logic [1:0] rsv_q, rsv_d;
    logic [1:0] xtype_q, xtype_d;

    // Interrupt masks and address-fix mode.
    logic       int_en_q, int_en_d;
    logic       eob_msk_q, eob_msk_d;
    logic       ver_msk_q, ver_msk_d;
    logic [1:0] incmode_q, incmode_d;

    // Counters and their written shadows.
    logic [15:0]       ca_q, ca_d, ca_s_q, ca_s_d;
    logic [15:0]       len_q, len_d, len_s_q, len_s_d;
    logic [REUA_W-1:0] reua_q, reua_d, reua_s_q, reua_s_d;

    logic [10:0]       wr_sel;
    logic              rd_st;
    logic              autoload;
    logic              set_any;
    logic              ca_cnt;
    logic              reua_cnt;
    logic              ca_rl;
    logic              len_rl;
    logic              reua_rl;
    logic [15:0]       ca_inc;
    logic [15:0]       len_dec;
    logic [REUA_W-1:0] reua_inc;
    logic [7:0]        rd6;

    // Register write decode and shared control terms.
    always_comb begin
        for (int i = 0; i < 11; i++) begin
            wr_sel[i] = bus.RegWR && (bus.A == 5'(i));
        end
        rd_st    = bus.RegRD && (bus.A == 5'd0);
        autoload = autold_en_q & XferEnd;
        set_any  = SetEndOfBlock | SetVerifyErr;
        ca_cnt   = IncCA & ~incmode_q[1];
        reua_cnt = IncREUA & ~incmode_q[0];
        ca_rl    = autoload | wr_sel[2] | wr_sel[3];
        len_rl   = autoload | wr_sel[7] | wr_sel[8];
        reua_rl  = autoload | wr_sel[4] | wr_sel[5];
        ca_inc   = ca_q + 16'd1;
        len_dec  = len_q - 16'd1;
        reua_inc = reua_q + REUA_W'(1);
    end

    // Status flags: a set strobe beats the clearing read, and a flag
    // that lands during the read raises IntPending so it is not lost.
    always_comb begin
        eob_d   = SetEndOfBlock | (eob_q & ~rd_st);
        fault_d = SetVerifyErr | (fault_q & ~rd_st);
        ipend_d = rd_st ? set_any : ipend_q;
    end

    // Command register: CPU write wins over end-of-transfer clearing.
    always_comb begin
        exec_en_d   = exec_en_q;
        rsv6_d      = rsv6_q;
        autold_en_d = autold_en_q;
        ff00_en_d   = ff00_en_q;
        rsv_d       = rsv_q;
        xtype_d     = xtype_q;
        if (wr_sel[1]) begin
            exec_en_d   = bus.WRD[7];
            rsv6_d      = bus.WRD[6];
            autold_en_d = bus.WRD[5];
            ff00_en_d   = ~bus.WRD[4];
            rsv_d       = bus.WRD[3:2];
            xtype_d     = bus.WRD[1:0];
        end else if (XferEnd) begin
            exec_en_d = 1'b0;
            ff00_en_d = 1'b0;
        end
    end

    // Interrupt mask and address-control registers.
    always_comb begin
        int_en_d  = int_en_q;
        eob_msk_d = eob_msk_q;
        ver_msk_d = ver_msk_q;
        incmode_d = incmode_q;
        if (wr_sel[9]) begin
            int_en_d  = bus.WRD[7];
            eob_msk_d = bus.WRD[6];
            ver_msk_d = bus.WRD[5];
        end
        if (wr_sel[10]) begin
            incmode_d = bus.WRD[7:6];
        end
    end

    // C64 address: per byte, write then reload then count.
    always_comb begin
        ca_s_d = ca_s_q;
        if (wr_sel[2]) ca_s_d[7:0]  = bus.WRD;
        if (wr_sel[3]) ca_s_d[15:8] = bus.WRD;

        if (wr_sel[2])   ca_d[7:0] = bus.WRD;
        else if (ca_rl)  ca_d[7:0] = ca_s_q[7:0];
        else if (ca_cnt) ca_d[7:0] = ca_inc[7:0];
        else             ca_d[7:0] = ca_q[7:0];

        if (wr_sel[3])   ca_d[15:8] = bus.WRD;
        else if (ca_rl)  ca_d[15:8] = ca_s_q[15:8];
        else if (ca_cnt) ca_d[15:8] = ca_inc[15:8];
        else             ca_d[15:8] = ca_q[15:8];
    end

    // Transfer length: per byte, write then reload then decrement.
    always_comb begin
        len_s_d = len_s_q;
        if (wr_sel[7]) len_s_d[7:0]  = bus.WRD;
        if (wr_sel[8]) len_s_d[15:8] = bus.WRD;

        if (wr_sel[7])    len_d[7:0] = bus.WRD;
        else if (len_rl)  len_d[7:0] = len_s_q[7:0];
        else if (DecLen)  len_d[7:0] = len_dec[7:0];
        else              len_d[7:0] = len_q[7:0];

        if (wr_sel[8])    len_d[15:8] = bus.WRD;
        else if (len_rl)  len_d[15:8] = len_s_q[15:8];
        else if (DecLen)  len_d[15:8] = len_dec[15:8];
        else              len_d[15:8] = len_q[15:8];
    end

    // REU address: lo/mid reload as a pair, the top byte stands alone.
    always_comb begin
        reua_s_d = reua_s_q;
        if (wr_sel[4]) reua_s_d[7:0]         = bus.WRD;
        if (wr_sel[5]) reua_s_d[15:8]        = bus.WRD;
        if (wr_sel[6]) reua_s_d[REUA_W-1:16] = bus.WRD[HW-1:0];

        if (wr_sel[4])     reua_d[7:0] = bus.WRD;
        else if (reua_rl)  reua_d[7:0] = reua_s_q[7:0];
        else if (reua_cnt) reua_d[7:0] = reua_inc[7:0];
        else               reua_d[7:0] = reua_q[7:0];

        if (wr_sel[5])     reua_d[15:8] = bus.WRD;
        else if (reua_rl)  reua_d[15:8] = reua_s_q[15:8];
        else if (reua_cnt) reua_d[15:8] = reua_inc[15:8];
        else               reua_d[15:8] = reua_q[15:8];

        if (wr_sel[6])
            reua_d[REUA_W-1:16] = bus.WRD[HW-1:0];
        else if (autoload)
            reua_d[REUA_W-1:16] = reua_s_q[REUA_W-1:16];
        else if (reua_cnt)
            reua_d[REUA_W-1:16] = reua_inc[REUA_W-1:16];
        else
            reua_d[REUA_W-1:16] = reua_q[REUA_W-1:16];
    end

    // All state advances on the PHI2 falling edge; Reset overrides all.
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            ipend_q     <= 1'b0;
            eob_q       <= 1'b0;
            fault_q     <= 1'b0;
            exec_en_q   <= 1'b0;
            rsv6_q      <= 1'b0;
            autold_en_q <= 1'b0;
            ff00_en_q   <= 1'b0;
            rsv_q       <= 2'b00;
            xtype_q     <= 2'b00;
            int_en_q    <= 1'b0;
            eob_msk_q   <= 1'b0;
            ver_msk_q   <= 1'b0;
            incmode_q   <= 2'b00;
            ca_q        <= 16'h0000;
            ca_s_q      <= 16'h0000;
            len_q       <= 16'hFFFF;
            len_s_q     <= 16'hFFFF;
            reua_q      <= '0;
            reua_s_q    <= '0;
        end else begin
            ipend_q     <= ipend_d;
            eob_q       <= eob_d;
            fault_q     <= fault_d;
            exec_en_q   <= exec_en_d;
            rsv6_q      <= rsv6_d;
            autold_en_q <= autold_en_d;
            ff00_en_q   <= ff00_en_d;
            rsv_q       <= rsv_d;
            xtype_q     <= xtype_d;
            int_en_q    <= int_en_d;
            eob_msk_q   <= eob_msk_d;
            ver_msk_q   <= ver_msk_d;
            incmode_q   <= incmode_d;
            ca_q        <= ca_d;
            ca_s_q      <= ca_s_d;
            len_q       <= len_d;
            len_s_q     <= len_s_d;
            reua_q      <= reua_d;
            reua_s_q    <= reua_s_d;
        end
    end

    // CPU read mux; unimplemented REU address bits read as 1.
    always_comb begin
        rd6          = 8'hFF;
        rd6[HW-1:0]  = reua_q[REUA_W-1:16];
        case (bus.A)
            5'd0:    bus.RDD = {ipend_q, eob_q, fault_q, SIZE_BIT, 4'b0000};
            5'd1:    bus.RDD = {exec_en_q, rsv6_q, autold_en_q, ~ff00_en_q,
                                rsv_q, xtype_q};
            5'd2:    bus.RDD = ca_q[7:0];
            5'd3:    bus.RDD = ca_q[15:8];
            5'd4:    bus.RDD = reua_q[7:0];
            5'd5:    bus.RDD = reua_q[15:8];
            5'd6:    bus.RDD = rd6;
            5'd7:    bus.RDD = len_q[7:0];
            5'd8:    bus.RDD = len_q[15:8];
            5'd9:    bus.RDD = {int_en_q, eob_msk_q, ver_msk_q, 5'b11111};
            5'd10:   bus.RDD = {incmode_q, 6'b111111};
            default: bus.RDD = 8'hFF;
        endcase
    end

    // Sequencer-facing outputs; command write bypasses straight through.
    always_comb begin
        XferTypeOut = wr_sel[1] ? bus.WRD[1:0] : xtype_q;
        Execute     = (ff00_en_q & exec_en_q & bus.FF00WR) |
                      (wr_sel[1] & bus.WRD[7] & bus.WRD[4]);
        IRQOut      = int_en_q & ((eob_q & eob_msk_q) |
                                  (fault_q & ver_msk_q));
        REUAOut     = reua_q;
        CAOut       = ca_q;
        Length1     = (len_q == 16'd1);
        Length2     = (len_q == 16'd2);
    end

endmodule

// File: tb/tb_reu_reg_param.sv
// tb_reu_reg_param: directed stimulus for the REU register file with a
// queue-based scoreboard checked at the PHI2 rising edge.
module tb_reu_reg_param;

    logic        PHI2 = 1'b1;
    logic        Reset;
    logic        IncCA, IncREUA, DecLen, XferEnd;
    logic        SetEndOfBlock, SetVerifyErr;
    logic        IRQOut;
    logic [1:0]  XferTypeOut;
    logic [18:0] REUAOut;
    logic [15:0] CAOut;
    logic        Length1, Length2, Execute;

    reu_reg_param_if bus ();

    reu_reg_param #(
        .REUA_W   (19),
        .SIZE_BIT (1'b1)
    ) dut (
        .PHI2          (PHI2),
        .Reset         (Reset),
        .bus           (bus),
        .IncCA         (IncCA),
        .IncREUA       (IncREUA),
        .DecLen        (DecLen),
        .XferEnd       (XferEnd),
        .SetEndOfBlock (SetEndOfBlock),
        .SetVerifyErr  (SetVerifyErr),
        .IRQOut        (IRQOut),
        .XferTypeOut   (XferTypeOut),
        .REUAOut       (REUAOut),
        .CAOut         (CAOut),
        .Length1       (Length1),
        .Length2       (Length2),
        .Execute       (Execute)
    );

    initial forever #10 PHI2 = ~PHI2;

    localparam int S_RDD  = 0;
    localparam int S_IRQ  = 1;
    localparam int S_XT   = 2;
    localparam int S_REUA = 3;
    localparam int S_CA   = 4;
    localparam int S_L1   = 5;
    localparam int S_L2   = 6;
    localparam int S_EXE  = 7;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q_exp[$];
    int          q_sel[$];
    string       q_nm[$];

    function automatic logic [31:0] probe(int s);
        case (s)
            S_RDD:   return 32'(bus.RDD);
            S_IRQ:   return 32'(IRQOut);
            S_XT:    return 32'(XferTypeOut);
            S_REUA:  return 32'(REUAOut);
            S_CA:    return 32'(CAOut);
            S_L1:    return 32'(Length1);
            S_L2:    return 32'(Length2);
            S_EXE:   return 32'(Execute);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle.
    always @(posedge PHI2) begin : mon
        logic [31:0] e, a;
        int          s;
        string       n;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            s = q_sel.pop_front();
            n = q_nm.pop_front();
            a = probe(s);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    task automatic push(input int s, input logic [31:0] e,
                        input string n);
        q_sel.push_back(s);
        q_exp.push_back(e);
        q_nm.push_back(n);
    endtask

    task automatic clr();
        Reset         = 1'b0;
        IncCA         = 1'b0;
        IncREUA       = 1'b0;
        DecLen        = 1'b0;
        XferEnd       = 1'b0;
        SetEndOfBlock = 1'b0;
        SetVerifyErr  = 1'b0;
        bus.RegRD     = 1'b0;
        bus.RegWR     = 1'b0;
        bus.FF00WR    = 1'b0;
        bus.A         = 5'd0;
        bus.WRD       = 8'h00;
    endtask

    task automatic nxt();
        @(negedge PHI2);
        #1;
        clr();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.RegWR = 1'b1;
        bus.A     = a;
        bus.WRD   = d;
        nxt();
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e,
                      input string n);
        bus.RegRD = 1'b1;
        bus.A     = a;
        push(S_RDD, 32'(e), n);
        nxt();
    endtask

    initial begin
        clr();
        Reset = 1'b1;
        @(negedge PHI2);
        #1;
        nxt();

        // Reset state
        push(S_IRQ, 0, "rst_irq");
        push(S_EXE, 0, "rst_exe");
        push(S_L1, 0, "rst_len1");
        push(S_L2, 0, "rst_len2");
        push(S_REUA, 0, "rst_reua");
        push(S_CA, 0, "rst_ca");
        push(S_XT, 0, "rst_xt");
        nxt();
        rd(5'h00, 8'h10, "rst_r0");
        rd(5'h01, 8'h10, "rst_r1");
        rd(5'h02, 8'h00, "rst_r2");
        rd(5'h03, 8'h00, "rst_r3");
        rd(5'h04, 8'h00, "rst_r4");
        rd(5'h05, 8'h00, "rst_r5");
        rd(5'h06, 8'hF8, "rst_r6");
        rd(5'h07, 8'hFF, "rst_r7");
        rd(5'h08, 8'hFF, "rst_r8");
        rd(5'h09, 8'h1F, "rst_r9");
        rd(5'h0A, 8'h3F, "rst_rA");
        rd(5'h0B, 8'hFF, "rst_rB");
        rd(5'h1F, 8'hFF, "rst_r1F");

        // REU address wrap at 2^19-1
        wr(5'h0A, 8'h00);
        wr(5'h04, 8'hFF);
        wr(5'h05, 8'hFF);
        wr(5'h06, 8'h07);
        push(S_REUA, 32'h7FFFF, "reua_load");
        IncREUA = 1'b1;
        nxt();
        push(S_REUA, 32'h00000, "reua_wrap");
        rd(5'h06, 8'hF8, "reua_wrap_r6");
        wr(5'h04, 8'h34);
        push(S_REUA, 32'h0FF34, "reua_pair");
        nxt();

        // Fixed REU address, CA still counts
        wr(5'h0A, 8'h40);
        rd(5'h0A, 8'h7F, "incmode_rd");
        wr(5'h04, 8'hFF);
        wr(5'h05, 8'hFF);
        wr(5'h06, 8'h07);
        IncREUA = 1'b1;
        IncCA   = 1'b1;
        nxt();
        push(S_REUA, 32'h7FFFF, "reua_fixed");
        push(S_CA, 32'h0001, "ca_cnt_fixed");
        nxt();

        // CA/length counting and autoload
        wr(5'h0A, 8'h00);
        wr(5'h02, 8'hFF);
        wr(5'h03, 8'h12);
        wr(5'h07, 8'h02);
        wr(5'h08, 8'h00);
        wr(5'h01, 8'h20);
        push(S_CA, 32'h12FF, "ca_load");
        push(S_L2, 1, "len2_load");
        IncCA  = 1'b1;
        DecLen = 1'b1;
        nxt();
        push(S_CA, 32'h1300, "ca_carry");
        push(S_L1, 1, "len1_dec");
        push(S_L2, 0, "len2_dec");
        nxt();
        XferEnd = 1'b1;
        nxt();
        push(S_CA, 32'h12FF, "ca_autold");
        push(S_L2, 1, "len2_autold");
        push(S_REUA, 32'h7FFFF, "reua_autold");
        rd(5'h01, 8'h30, "r1_xferend");

        // Length 0 - 1 wraps to FFFF
        wr(5'h07, 8'h00);
        wr(5'h08, 8'h00);
        DecLen = 1'b1;
        nxt();
        rd(5'h07, 8'hFF, "len_wrap_lo");
        rd(5'h08, 8'hFF, "len_wrap_hi");

        // Execute via $FF00 and via direct command write
        bus.RegWR = 1'b1;
        bus.A     = 5'h01;
        bus.WRD   = 8'h80;
        push(S_EXE, 0, "exe_arm");
        nxt();
        bus.FF00WR = 1'b1;
        push(S_EXE, 1, "exe_ff00");
        nxt();
        bus.RegWR = 1'b1;
        bus.A     = 5'h01;
        bus.WRD   = 8'h92;
        push(S_EXE, 1, "exe_direct");
        push(S_XT, 2, "xt_bypass");
        nxt();
        push(S_EXE, 0, "exe_idle");
        push(S_XT, 2, "xt_held");
        nxt();
        bus.RegWR = 1'b1;
        bus.A     = 5'h01;
        bus.WRD   = 8'h80;
        XferEnd   = 1'b1;
        nxt();
        bus.FF00WR = 1'b1;
        push(S_EXE, 1, "exe_wr_wins");
        nxt();
        XferEnd = 1'b1;
        nxt();
        bus.FF00WR = 1'b1;
        push(S_EXE, 0, "exe_cleared");
        nxt();
        rd(5'h01, 8'h10, "r1_cleared");

        // Interrupts and status read/set race
        wr(5'h09, 8'hE0);
        rd(5'h09, 8'hFF, "r9_masks");
        SetVerifyErr = 1'b1;
        nxt();
        push(S_IRQ, 1, "irq_fault");
        nxt();
        rd(5'h00, 8'h30, "r0_fault");
        push(S_IRQ, 0, "irq_cleared");
        rd(5'h00, 8'h10, "r0_cleared");
        bus.RegRD     = 1'b1;
        bus.A         = 5'h00;
        SetEndOfBlock = 1'b1;
        push(S_RDD, 32'h10, "r0_race");
        nxt();
        push(S_IRQ, 1, "irq_eob");
        rd(5'h00, 8'hD0, "r0_race_set");
        push(S_IRQ, 0, "irq_eob_clr");
        rd(5'h00, 8'h10, "r0_race_clr");

        // Reset in the middle of a transfer
        wr(5'h02, 8'h55);
        SetVerifyErr = 1'b1;
        nxt();
        push(S_IRQ, 1, "irq_pre_rst");
        nxt();
        Reset         = 1'b1;
        IncREUA       = 1'b1;
        IncCA         = 1'b1;
        DecLen        = 1'b1;
        XferEnd       = 1'b1;
        SetEndOfBlock = 1'b1;
        bus.RegWR     = 1'b1;
        bus.A         = 5'h04;
        bus.WRD       = 8'hAA;
        nxt();
        push(S_REUA, 0, "mid_rst_reua");
        push(S_CA, 0, "mid_rst_ca");
        push(S_L1, 0, "mid_rst_len1");
        push(S_L2, 0, "mid_rst_len2");
        push(S_IRQ, 0, "mid_rst_irq");
        push(S_XT, 0, "mid_rst_xt");
        nxt();
        rd(5'h00, 8'h10, "mid_rst_r0");
        rd(5'h01, 8'h10, "mid_rst_r1");
        rd(5'h04, 8'h00, "mid_rst_r4");
        rd(5'h07, 8'hFF, "mid_rst_r7");
        rd(5'h09, 8'h1F, "mid_rst_r9");
        rd(5'h0A, 8'h3F, "mid_rst_rA");
        rd(5'h06, 8'hF8, "mid_rst_r6");
        wr(5'h05, 8'h12);
        push(S_REUA, 32'h01200, "mid_rst_shadow");
        nxt();

        repeat (3) @(negedge PHI2);
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
